// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: lsu load/store sequencing, misalignment traps, WB handoff
module mem_stage #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 32,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic              in_mem_ren,
  input  logic              in_mem_wen,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [4:0]        in_rd,
  input  logic              in_rd_wen,
  output logic [2:0]        lsu_funct3,
  output logic [ADDR_W-1:0] lsu_addr,
  output logic              lsu_r_ready,
  input  logic [DATA_W-1:0] lsu_r_data,
  input  logic              lsu_r_valid,
  output logic              lsu_w_valid,
  output logic [DATA_W-1:0] lsu_w_data,
  input  logic              lsu_w_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [4:0]        out_rd,
  output logic              out_rd_wen,
  output logic [DATA_W-1:0] out_rd_data,
  output logic              out_exc,
  output logic [3:0]        out_exc_cause,
  output logic [31:0]       out_exc_tval
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, HOLD} state_t;

  state_t            r_state;
  state_t            w_next;
  state_t            w_acc_state;
  logic              w_accept;
  logic              w_misaligned;
  logic              w_mem;

  logic [31:0]       r_pc;
  logic [4:0]        r_rd;
  logic              r_rd_wen;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_exc;
  logic [3:0]        r_cause;
  logic [31:0]       r_tval;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_kill;

  assign w_mem = in_mem_ren | in_mem_wen;

  // funct3[1:0] encodes access size: 0 byte, 1 half, 2 word, 3 double
  always_comb begin
    w_misaligned = 1'b0;
    if (ALIGN_CHECK != 0 && w_mem) begin
      case (in_funct3[1:0])
        2'd1:    w_misaligned = in_addr[0];
        2'd2:    w_misaligned = |in_addr[1:0];
        2'd3:    w_misaligned = |in_addr[2:0];
        default: w_misaligned = 1'b0;
      endcase
    end
  end

  assign in_ready = (r_state == IDLE) | ((r_state == HOLD) & out_ready);
  assign w_accept = in_valid & in_ready & ~flush;

  always_comb begin
    w_acc_state = HOLD;
    if (!w_misaligned) begin
      if (in_mem_ren)      w_acc_state = RD_WAIT;
      else if (in_mem_wen) w_acc_state = WR_WAIT;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = w_acc_state;
      end
      RD_WAIT: begin
        if (lsu_r_valid) w_next = (r_kill | flush) ? IDLE : HOLD;
      end
      WR_WAIT: begin
        if (lsu_w_ready) w_next = (r_kill | flush) ? IDLE : HOLD;
      end
      HOLD: begin
        if (flush)          w_next = IDLE;
        else if (out_ready) w_next = w_accept ? w_acc_state : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= '0;
      r_rd      <= '0;
      r_rd_wen  <= 1'b0;
      r_rd_data <= '0;
      r_exc     <= 1'b0;
      r_cause   <= '0;
      r_tval    <= '0;
      r_funct3  <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_kill    <= 1'b0;
    end else if (w_accept) begin
      r_pc      <= in_pc;
      r_rd      <= in_rd;
      r_rd_wen  <= in_rd_wen & ~w_misaligned & ~in_mem_wen;
      r_rd_data <= w_mem ? '0 : in_alu_result;
      r_exc     <= w_misaligned;
      r_cause   <= w_misaligned ? (in_mem_ren ? 4'd4 : 4'd6) : 4'd0;
      r_tval    <= w_misaligned ? 32'(in_addr) : 32'd0;
      r_funct3  <= in_funct3;
      r_addr    <= in_addr;
      r_wdata   <= in_wdata;
      r_kill    <= 1'b0;
    end else begin
      // an in-flight bus access cannot be aborted, so a flush only marks it for discard
      if (r_state == RD_WAIT) begin
        if (lsu_r_valid) begin
          r_rd_data <= lsu_r_data;
          r_kill    <= 1'b0;
        end else if (flush) begin
          r_kill <= 1'b1;
        end
      end
      if (r_state == WR_WAIT) begin
        if (lsu_w_ready) begin
          r_rd_wen <= 1'b0;
          r_kill   <= 1'b0;
        end else if (flush) begin
          r_kill <= 1'b1;
        end
      end
    end
  end

  assign lsu_funct3    = r_funct3;
  assign lsu_addr      = r_addr;
  assign lsu_w_data    = r_wdata;
  assign lsu_r_ready   = (r_state == RD_WAIT) & ~lsu_r_valid;
  assign lsu_w_valid   = (r_state == WR_WAIT) & ~lsu_w_ready;

  assign out_valid     = (r_state == HOLD);
  assign out_pc        = r_pc;
  assign out_rd        = r_rd;
  assign out_rd_wen    = r_rd_wen;
  assign out_rd_data   = r_rd_data;
  assign out_exc       = r_exc;
  assign out_exc_cause = r_cause;
  assign out_exc_tval  = r_tval;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic        in_mem_ren;
  logic        in_mem_wen;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [63:0] in_wdata;
  logic [63:0] in_alu_result;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic        lsu_r_ready;
  logic [63:0] lsu_r_data;
  logic        lsu_r_valid;
  logic        lsu_w_valid;
  logic [63:0] lsu_w_data;
  logic        lsu_w_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic [63:0] out_rd_data;
  logic        out_exc;
  logic [3:0]  out_exc_cause;
  logic [31:0] out_exc_tval;

  int n_vec  = 0;
  int n_miss = 0;

  mem_stage #(.DATA_W(64), .ADDR_W(32), .ALIGN_CHECK(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_mem_ren(in_mem_ren), .in_mem_wen(in_mem_wen), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_alu_result(in_alu_result),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_r_ready(lsu_r_ready),
    .lsu_r_data(lsu_r_data), .lsu_r_valid(lsu_r_valid),
    .lsu_w_valid(lsu_w_valid), .lsu_w_data(lsu_w_data), .lsu_w_ready(lsu_w_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
    .out_rd_wen(out_rd_wen), .out_rd_data(out_rd_data), .out_exc(out_exc),
    .out_exc_cause(out_exc_cause), .out_exc_tval(out_exc_tval)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic ren, input logic wen, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [63:0] wd,
                       input logic [63:0] alu, input logic [4:0] rd, input logic rdw);
    in_valid = 1'b1; in_mem_ren = ren; in_mem_wen = wen; in_funct3 = f3;
    in_addr = addr; in_wdata = wd; in_alu_result = alu; in_rd = rd; in_rd_wen = rdw;
    in_pc = in_pc + 32'd4;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = 32'h1000;
    in_mem_ren = 1'b0; in_mem_wen = 1'b0; in_funct3 = 3'd0; in_addr = '0;
    in_wdata = '0; in_alu_result = '0; in_rd = '0; in_rd_wen = 1'b0;
    lsu_r_data = '0; lsu_r_valid = 1'b0; lsu_w_ready = 1'b0; out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_rd_wen", 64'(out_rd_wen), 64'd0);
    check("rst_r_ready", 64'(lsu_r_ready), 64'd0);
    rst = 1'b0;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);

    // ALU pass-through, back-to-back
    @(negedge clk);
    issue(1'b0, 1'b0, 3'd0, 32'd0, 64'd0, 64'h1234, 5'd5, 1'b1);
    @(negedge clk);
    check("alu_valid", 64'(out_valid), 64'd1);
    check("alu_data", out_rd_data, 64'h1234);
    check("alu_rd", 64'(out_rd), 64'd5);
    check("alu_rd_wen", 64'(out_rd_wen), 64'd1);
    check("alu_in_ready", 64'(in_ready), 64'd1);
    issue(1'b0, 1'b0, 3'd0, 32'd0, 64'd0, 64'h5678, 5'd6, 1'b1);
    @(negedge clk);
    check("b2b_valid", 64'(out_valid), 64'd1);
    check("b2b_data", out_rd_data, 64'h5678);
    check("b2b_rd", 64'(out_rd), 64'd6);
    in_valid = 1'b0;
    @(negedge clk);
    check("alu_idle", 64'(out_valid), 64'd0);

    // LW with a 3-cycle lsu latency
    issue(1'b1, 1'b0, 3'b010, 32'h8000_0004, 64'd0, 64'd0, 5'd9, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("lw_r_ready_hi", 64'(lsu_r_ready), 64'd1);
      check("lw_addr", 64'(lsu_addr), 64'h8000_0004);
      @(negedge clk);
    end
    check("lw_no_valid_yet", 64'(out_valid), 64'd0);
    lsu_r_valid = 1'b1; lsu_r_data = 64'hFFFF_FFFF_8000_0000;
    #1 check("lw_r_ready_drop", 64'(lsu_r_ready), 64'd0);
    @(negedge clk);
    lsu_r_valid = 1'b0;
    check("lw_valid", 64'(out_valid), 64'd1);
    check("lw_data", out_rd_data, 64'hFFFF_FFFF_8000_0000);
    check("lw_rd_wen", 64'(out_rd_wen), 64'd1);
    check("lw_r_ready_hold", 64'(lsu_r_ready), 64'd0);
    @(negedge clk);

    // SD: write request held until completion, rd_wen forced off
    issue(1'b0, 1'b1, 3'b011, 32'hA000_0000, 64'hDEAD_BEEF, 64'd0, 5'd3, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("sd_w_valid_hi", 64'(lsu_w_valid), 64'd1);
      check("sd_w_data", lsu_w_data, 64'hDEAD_BEEF);
      check("sd_no_read", 64'(lsu_r_ready), 64'd0);
      @(negedge clk);
    end
    lsu_w_ready = 1'b1;
    #1 check("sd_w_valid_drop", 64'(lsu_w_valid), 64'd0);
    @(negedge clk);
    lsu_w_ready = 1'b0;
    check("sd_valid", 64'(out_valid), 64'd1);
    check("sd_rd_wen", 64'(out_rd_wen), 64'd0);
    check("sd_exc", 64'(out_exc), 64'd0);
    check("sd_w_valid_hold", 64'(lsu_w_valid), 64'd0);
    @(negedge clk);

    // misaligned LH then SW, back-to-back, no lsu traffic
    issue(1'b1, 1'b0, 3'b001, 32'h8000_0001, 64'd0, 64'd0, 5'd4, 1'b1);
    @(negedge clk);
    check("lh_exc", 64'(out_exc), 64'd1);
    check("lh_cause", 64'(out_exc_cause), 64'd4);
    check("lh_tval", 64'(out_exc_tval), 64'h8000_0001);
    check("lh_rd_wen", 64'(out_rd_wen), 64'd0);
    check("lh_no_read", 64'(lsu_r_ready), 64'd0);
    issue(1'b0, 1'b1, 3'b010, 32'h8000_0002, 64'h55, 64'd0, 5'd0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("sw_valid", 64'(out_valid), 64'd1);
    check("sw_cause", 64'(out_exc_cause), 64'd6);
    check("sw_tval", 64'(out_exc_tval), 64'h8000_0002);
    check("sw_no_write", 64'(lsu_w_valid), 64'd0);
    @(negedge clk);

    // aligned LB at odd address is not an exception
    issue(1'b1, 1'b0, 3'b000, 32'h8000_0003, 64'd0, 64'd0, 5'd8, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("lb_r_ready", 64'(lsu_r_ready), 64'd1);
    lsu_r_valid = 1'b1; lsu_r_data = 64'h7F;
    @(negedge clk);
    lsu_r_valid = 1'b0;
    check("lb_exc", 64'(out_exc), 64'd0);
    check("lb_data", out_rd_data, 64'h7F);
    @(negedge clk);

    // WB backpressure: outputs stable, no acceptance
    out_ready = 1'b0;
    issue(1'b0, 1'b0, 3'd0, 32'd0, 64'd0, 64'hAAAA, 5'd7, 1'b1);
    @(negedge clk);
    in_alu_result = 64'hBBBB; in_rd = 5'd10;
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", out_rd_data, 64'hAAAA);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_data", out_rd_data, 64'hBBBB);
    check("bp_next_rd", 64'(out_rd), 64'd10);
    @(negedge clk);

    // flush while holding a result
    out_ready = 1'b0;
    issue(1'b0, 1'b0, 3'd0, 32'd0, 64'd0, 64'h11, 5'd1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("fh_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b1;
    check("fh_dropped", 64'(out_valid), 64'd0);

    // flush during RD_WAIT: access completes, result discarded
    issue(1'b1, 1'b0, 3'b011, 32'h8000_0010, 64'd0, 64'd0, 5'd2, 1'b1);
    @(negedge clk);
    flush = 1'b1;
    check("frd_r_ready", 64'(lsu_r_ready), 64'd1);
    check("frd_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    check("frd_r_ready2", 64'(lsu_r_ready), 64'd1);
    check("frd_in_ready2", 64'(in_ready), 64'd0);
    lsu_r_valid = 1'b1; lsu_r_data = 64'h99;
    #1 check("frd_r_drop", 64'(lsu_r_ready), 64'd0);
    @(negedge clk);
    lsu_r_valid = 1'b0; in_valid = 1'b0;
    check("frd_no_valid", 64'(out_valid), 64'd0);
    check("frd_in_ready3", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("frd_no_valid2", 64'(out_valid), 64'd0);

    // asynchronous reset mid RD_WAIT
    issue(1'b1, 1'b0, 3'b010, 32'h8000_0020, 64'd0, 64'd0, 5'd2, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("arst_r_ready_pre", 64'(lsu_r_ready), 64'd1);
    #2 rst = 1'b1;
    #1 check("arst_r_ready", 64'(lsu_r_ready), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_addr", 64'(lsu_addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("arst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("arst_idle", 64'(lsu_r_ready), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
